regbank_wb_arbiter: RTL and testbench

//  Shares the register bank's single write port (w/AddrC/DataC) between two writeback sources:
//  ALU results and memory load results. Fair round-robin arbitration; registered write outputs.

---
 rtl/regbank_wb_arbiter_pkg.sv | 14 +
 rtl/regbank_wb_arbiter_if.sv | 36 +++
 rtl/regbank_wb_arbiter_rr_arb2.sv | 37 +++
 rtl/regbank_wb_arbiter.sv | 98 +++++++++
 tb/tb_regbank_wb_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/regbank_wb_arbiter_pkg.sv
// Shared constants and types for the register-bank writeback arbiter.
// Widths and the read-as-zero register index match the regbank.
package regbank_pkg;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam logic [AW-1:0] ZERO_REG = 5'd31;

  typedef enum logic [0:0] {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_t;

endpackage

// File: rtl/regbank_wb_arbiter_if.sv
// Bundle of writeback requests, scoreboard issue/check and regbank write port.
// The arbiter takes the slave side; the surrounding pipeline (or bench) takes master.
interface regbank_wb_arbiter_if;
  import regbank_pkg::*;

  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic          issue_valid;
  logic [AW-1:0] issue_addr;
  logic [AW-1:0] chk_addr_a;
  logic [AW-1:0] chk_addr_b;
  logic          busy_a;
  logic          busy_b;
  logic          rb_w;
  logic [AW-1:0] rb_addr;
  logic [DW-1:0] rb_data;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           issue_valid, issue_addr, chk_addr_a, chk_addr_b,
    input  alu_ready, mem_ready, busy_a, busy_b, rb_w, rb_addr, rb_data
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           issue_valid, issue_addr, chk_addr_a, chk_addr_b,
    output alu_ready, mem_ready, busy_a, busy_b, rb_w, rb_addr, rb_data
  );

endinterface

// File: rtl/regbank_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is the ALU, bit 1 is the load unit.
// The most recently accepted requester loses the next tie.
module rr_arb2
  import regbank_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);

  req_id_t r_last;

  // grant selection
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (r_last == REQ_MEM) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  // last-grant tracking, reset so the ALU wins the first tie
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= REQ_MEM;
    end else if (i_accept) begin
      r_last <= o_gnt[1] ? REQ_MEM : REQ_ALU;
    end else begin
      r_last <= r_last;
    end
  end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Shares the regbank write port between ALU and load writebacks and keeps the
// per-register busy scoreboard used by decode for RAW stalls.
module regbank_wb_arbiter
  import regbank_pkg::*;
(
  input  logic                   Clk,
  input  logic                   Reset,
  regbank_wb_arbiter_if.slave    bus
);

  logic [1:0]    w_gnt;
  logic          w_any_gnt;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          w_wr;
  logic [31:0]   w_busy_nxt;

  logic          r_rb_w;
  logic [AW-1:0] r_rb_addr;
  logic [DW-1:0] r_rb_data;
  logic [31:0]   r_busy;

  rr_arb2 u_arb (
    .i_clk    (Clk),
    .i_rst    (Reset),
    .i_req    ({bus.mem_valid, bus.alu_valid}),
    .i_accept (w_any_gnt),
    .o_gnt    (w_gnt)
  );

  assign w_any_gnt = |w_gnt;

  // source mux; a granted write to the zero register is accepted but dropped
  always_comb begin
    w_addr = bus.alu_addr;
    w_data = bus.alu_data;
    if (w_gnt[1]) begin
      w_addr = bus.mem_addr;
      w_data = bus.mem_data;
    end else begin
      w_addr = bus.alu_addr;
      w_data = bus.alu_data;
    end
    w_wr = w_any_gnt && (w_addr != ZERO_REG);
  end

  // regbank write port register stage
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rb_w    <= 1'b0;
      r_rb_addr <= {AW{1'b0}};
      r_rb_data <= {DW{1'b0}};
    end else begin
      r_rb_w <= w_wr;
      if (w_wr) begin
        r_rb_addr <= w_addr;
        r_rb_data <= w_data;
      end else begin
        r_rb_addr <= r_rb_addr;
        r_rb_data <= r_rb_data;
      end
    end
  end

  // commit clears first so a same-edge issue to that register wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_rb_w) begin
      w_busy_nxt[r_rb_addr] = 1'b0;
    end else begin
      w_busy_nxt = r_busy;
    end
    if (bus.issue_valid && (bus.issue_addr != ZERO_REG)) begin
      w_busy_nxt[bus.issue_addr] = 1'b1;
    end else begin
      w_busy_nxt[ZERO_REG] = 1'b0;
    end
    w_busy_nxt[ZERO_REG] = 1'b0;
  end

  // scoreboard register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_busy <= 32'h0000_0000;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign bus.alu_ready = w_gnt[0];
  assign bus.mem_ready = w_gnt[1];
  assign bus.busy_a    = r_busy[bus.chk_addr_a];
  assign bus.busy_b    = r_busy[bus.chk_addr_b];
  assign bus.rb_w      = r_rb_w;
  assign bus.rb_addr   = r_rb_addr;
  assign bus.rb_data   = r_rb_data;

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed and randomized bench for regbank_wb_arbiter against a behavioural model.
module tb_regbank_wb_arbiter;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  regbank_wb_arbiter_if bus ();

  regbank_wb_arbiter dut (
    .Clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // behavioural model: who went last (1 = load unit), busy set, pending regbank write
  bit          m_last_mem;
  bit [31:0]   m_busy;
  bit          m_rbw;
  logic [4:0]  m_rbaddr;
  logic [63:0] m_rbdata;
  bit          m_alu_won;
  bit          m_mem_won;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last_mem = 1'b1;
    m_busy     = 32'h0;
    m_rbw      = 1'b0;
    m_rbaddr   = 5'd0;
    m_rbdata   = 64'h0;
  endtask

  // one clock: check every output at the negedge, then advance the model at the posedge
  task automatic cyc();
    bit a_win, m_win;
    bit [31:0] nb;
    logic [4:0] wa;
    logic [63:0] wd;
    a_win = bus.alu_valid && (!bus.mem_valid || m_last_mem);
    m_win = bus.mem_valid && (!bus.alu_valid || !m_last_mem);
    @(negedge clk);
    chk("alu_ready", {63'h0, bus.alu_ready}, {63'h0, a_win});
    chk("mem_ready", {63'h0, bus.mem_ready}, {63'h0, m_win});
    chk("busy_a", {63'h0, bus.busy_a}, {63'h0, m_busy[bus.chk_addr_a]});
    chk("busy_b", {63'h0, bus.busy_b}, {63'h0, m_busy[bus.chk_addr_b]});
    chk("rb_w", {63'h0, bus.rb_w}, {63'h0, m_rbw});
    chk("rb_addr", {59'h0, bus.rb_addr}, {59'h0, m_rbaddr});
    chk("rb_data", bus.rb_data, m_rbdata);
    @(posedge clk);
    m_alu_won = a_win;
    m_mem_won = m_win;
    if (Reset) begin
      model_reset();
    end else begin
      nb = m_busy;
      if (m_rbw) nb[m_rbaddr] = 1'b0;
      if (bus.issue_valid && bus.issue_addr != 5'd31) nb[bus.issue_addr] = 1'b1;
      m_busy = nb;
      if (a_win || m_win) begin
        wa = a_win ? bus.alu_addr : bus.mem_addr;
        wd = a_win ? bus.alu_data : bus.mem_data;
        m_last_mem = m_win;
        m_rbw = (wa != 5'd31);
        if (wa != 5'd31) begin
          m_rbaddr = wa;
          m_rbdata = wd;
        end
      end else begin
        m_rbw = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_addr = 5'd0; bus.alu_data = 64'h0;
    bus.mem_valid = 1'b0; bus.mem_addr = 5'd0; bus.mem_data = 64'h0;
    bus.issue_valid = 1'b0; bus.issue_addr = 5'd0;
    bus.chk_addr_a = 5'd0; bus.chk_addr_b = 5'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    Reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("reset_rb_w", {63'h0, bus.rb_w}, 64'h0);
    chk("reset_rb_addr", {59'h0, bus.rb_addr}, 64'h0);
    chk("reset_rb_data", bus.rb_data, 64'h0);
    Reset = 1'b0;

    // 1: single ALU write, two-edge latency
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 64'hAA;
    cyc();
    chk("t1_alu_won", {63'h0, m_alu_won}, 64'h1);
    chk("t1_rb_w", {63'h0, bus.rb_w}, 64'h1);
    chk("t1_rb_addr", {59'h0, bus.rb_addr}, 64'h5);
    chk("t1_rb_data", bus.rb_data, 64'hAA);
    bus.alu_valid = 1'b0;
    cyc();
    chk("t1_rb_w_low", {63'h0, bus.rb_w}, 64'h0);

    // 2: both valid every cycle -> strict alternation starting with ALU
    do_reset();
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd1; bus.alu_data = 64'h1111;
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd2; bus.mem_data = 64'h2222;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t2_alu_turn", {63'h0, m_alu_won}, (i % 2 == 0) ? 64'h1 : 64'h0);
      chk("t2_rb_addr", {59'h0, bus.rb_addr}, (i % 2 == 0) ? 64'h1 : 64'h2);
    end

    // 3: zero-register write accepted, dropped, and still rotates priority
    bus.mem_valid = 1'b0;
    bus.alu_addr = 5'd31; bus.alu_data = 64'hFF;
    bus.chk_addr_a = 5'd31;
    cyc();
    chk("t3_alu_won", {63'h0, m_alu_won}, 64'h1);
    chk("t3_rb_w", {63'h0, bus.rb_w}, 64'h0);
    chk("t3_busy31", {63'h0, bus.busy_a}, 64'h0);
    bus.alu_addr = 5'd1; bus.mem_valid = 1'b1;
    cyc();
    chk("t3_tie_mem", {63'h0, m_mem_won}, 64'h1);
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    cyc();

    // 4: busy clears exactly at the commit edge
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd7; bus.chk_addr_a = 5'd7;
    cyc();
    bus.issue_valid = 1'b0;
    chk("t4_busy_set", {63'h0, bus.busy_a}, 64'h1);
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd7; bus.mem_data = 64'h7777;
    cyc();
    bus.mem_valid = 1'b0;
    chk("t4_busy_t1", {63'h0, bus.busy_a}, 64'h1);
    cyc();
    chk("t4_busy_t2", {63'h0, bus.busy_a}, 64'h0);

    // 5: same-edge issue and commit to register 9 -> set wins
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd9; bus.alu_data = 64'h9999;
    bus.chk_addr_b = 5'd9;
    cyc();
    bus.alu_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd9;
    cyc();
    bus.issue_valid = 1'b0;
    chk("t5_busy9", {63'h0, bus.busy_b}, 64'h1);

    // 6: reset right after a grant drops the write and all busy bits
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd3; bus.chk_addr_a = 5'd3;
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd4; bus.mem_data = 64'h4444;
    cyc();
    idle_inputs();
    bus.chk_addr_a = 5'd3; bus.chk_addr_b = 5'd9;
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    chk("t6_rb_w", {63'h0, bus.rb_w}, 64'h0);
    chk("t6_busy3", {63'h0, bus.busy_a}, 64'h0);
    chk("t6_busy9", {63'h0, bus.busy_b}, 64'h0);
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd6; bus.alu_data = 64'h6;
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd8; bus.mem_data = 64'h8;
    cyc();
    chk("t6_tie_alu", {63'h0, m_alu_won}, 64'h1);
    idle_inputs();
    cyc();

    // randomized traffic; requests are held until accepted
    for (int n = 0; n < 600; n++) begin
      if (!bus.alu_valid && ($urandom_range(0, 3) != 0)) begin
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 5'($urandom_range(0, 31));
        bus.alu_data  = {$urandom, $urandom};
      end
      if (!bus.mem_valid && ($urandom_range(0, 3) != 0)) begin
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 5'($urandom_range(0, 31));
        bus.mem_data  = {$urandom, $urandom};
      end
      bus.issue_valid = ($urandom_range(0, 2) == 0);
      bus.issue_addr  = 5'($urandom_range(0, 31));
      bus.chk_addr_a  = 5'($urandom_range(0, 31));
      bus.chk_addr_b  = 5'($urandom_range(0, 31));
      Reset = ($urandom_range(0, 99) == 0);
      cyc();
      if (Reset) begin
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
      end else begin
        if (m_alu_won) bus.alu_valid = 1'b0;
        if (m_mem_won) bus.mem_valid = 1'b0;
      end
      Reset = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
